instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of decode.
- Holds the PC, issues one request at a time to instruction memory, and buffers returned words in a small queue.
- Presents {instruction, pc} to decode over a valid/ready handshake; decode extracts opcode[6:0] from the instruction for the control unit.
- Accepts a redirect (taken branch / JAL / JALR target from execute) that flushes the queue and discards any in-flight response.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QUEUE_DEPTH, 2, instruction queue entries; power of two, >= 1.

Ports:
- clock  in  1  sole clock, rising edge.
- resetN  in  1  synchronous, active-low reset.
- imemReqValid  out  1  request valid.
- imemReqReady  in  1  memory accepts request.
- imemReqAddr  out  ADDR_WIDTH  word-aligned fetch address.
- imemRespValid  in  1  response data valid; at most one per accepted request, at any later cycle.
- imemRespData  in  32  instruction word.
- instrValid  out  1  queue head valid to decode.
- instrReady  in  1  decode consumes head.
- instruction  out  32  queue head instruction.
- instrPc  out  ADDR_WIDTH  PC of queue head.
- redirectValid  in  1  single-cycle redirect pulse.
- redirectPc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored and forced to 0.

Behaviour:
- Reset (resetN=0 at a clock edge):
  - pc = RESET_PC; state = FETCH; queue empty.
  - imemReqValid, instrValid, instruction, instrPc all 0 while resetN=0.
- States:
  - FETCH (no request outstanding).
  - WAIT (one request outstanding, response wanted).
  - DISCARD (one request outstanding, response to be dropped).
- FETCH:
  - imemReqValid = (count < QUEUE_DEPTH) and not redirectValid; imemReqAddr = pc.
  - On valid and ready: reqPc = pc; pc = pc + 4 (wraps modulo 2^ADDR_WIDTH); go to WAIT.
- WAIT:
  - imemReqValid = 0.
  - On imemRespValid: push {imemRespData, reqPc}; go to FETCH.
- DISCARD:
  - imemReqValid = 0.
  - On imemRespValid: drop the data; go to FETCH.
- Throughput: at most one instruction per 2 cycles (request and response never share a cycle within this block).
- No overflow: a request issues only when count < QUEUE_DEPTH with none outstanding, so the push always has space.
- Queue:
  - FIFO; head is driven combinationally from storage.
  - Pop when instrValid and instrReady.
  - Push and pop in the same cycle keep count unchanged.
  - instrValid = (count != 0).
- Redirect has top priority:
  - Queue cleared: instrValid = 0 from the next cycle; no pop is counted that cycle.
  - pc = {redirectPc[ADDR_WIDTH-1:2], 2'b00}.
  - State: WAIT without a response this cycle -> DISCARD; WAIT with a response this cycle -> response dropped, go to FETCH; DISCARD stays DISCARD; FETCH stays FETCH with no request issued that cycle.
  - Redirect in the same cycle as the reset edge: reset wins.
- Reset mid-request: state returns to FETCH; a late response arriving in FETCH is ignored.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- Defined: adds outputs fetchedCount[31:0] and starvedCycles[31:0], both reset to 0.
  - fetchedCount increments on each queue push.
  - starvedCycles increments each cycle instrValid=0 while resetN=1.
  - Both wrap at 2^32; neither is cleared by redirect.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package fetch_pkg holds: INSTR_WIDTH=32, PC_STEP=4, the fetch state encoding (FETCH, WAIT, DISCARD), and NOP_INSTR=32'h0000_0013 for benches.
- One sub-module, fetch_queue:
  - Parameterised depth/width FIFO with push, pop, flush, count, and head outputs.
  - Flush has priority over push.

Test Plan:
- Reset release, memory always ready, 1-cycle response, instrReady=1 -> addresses 0x0,0x4,0x8 requested every 2 cycles; instrPc sequence 0x0,0x4,0x8 with matching data.
- instrReady=0 with QUEUE_DEPTH=2 -> exactly 2 pushes (pc 0x0,0x4), then imemReqValid stays 0; raising instrReady resumes at 0x8.
- Redirect to 0x100 while in WAIT, response arrives 3 cycles later -> response dropped; next request address 0x100; instrValid low until 0x100 data returns.
- Redirect to 0x200 in the same cycle as imemRespValid -> data not pushed; next request 0x200.
- imemReqReady held low 5 cycles -> imemReqValid and imemReqAddr held stable; pc unchanged.
- resetN low while in WAIT, stale response arrives after release -> ignored; first request is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage.
//   INSTR_WIDTH   width of one instruction word
//   PC_STEP       byte increment between sequential fetches
//   fetch_state_e fetch FSM encoding (FETCH / WAIT / DISCARD)
//   NOP_INSTR     canonical NOP (addi x0,x0,0), handy for benches
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 4;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    // FETCH   : nothing outstanding, may issue a request
    // WAIT    : one request outstanding, its response will be queued
    // DISCARD : one request outstanding, its response is stale and dropped
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO holding fetched {instruction, pc} records.
// Ports:
//   clock      rising-edge clock
//   resetN     synchronous active-low reset (empties the queue)
//   flush      empties the queue; has priority over push
//   push       write pushData at the tail
//   pushData   record to write
//   pop        remove the head (ignored when empty)
//   headData   current head record, driven combinationally from storage
//   count      number of valid entries
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    // Pointers wrap explicitly so non-power-of-two pointer ranges stay safe.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign doPush = push && !flush;
    assign doPop  = pop && !flush && (count_q != '0);

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = nextPtr(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_d = nextPtr(rdPtr_q);
            end
            if (doPush && !doPop) begin
                count_d = count_q + 1'b1;
            end else if (doPop && !doPush) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData;
        end
    end

    assign headData = mem_q[rdPtr_q];
    assign count    = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage: owns the PC, issues one instruction-memory request at a time,
// queues returned words and hands {instruction, pc} to decode.
// Optional build macro: FETCH_PERF_COUNTERS_EN adds fetchedCount and
// starvedCycles performance counter outputs.
// Ports:
//   clock, resetN                 clock and synchronous active-low reset
//   imemReqValid/Ready/Addr       request channel to instruction memory
//   imemRespValid/Data            response channel (one per accepted request)
//   instrValid/Ready              handshake to decode
//   instruction, instrPc          queue head record
//   redirectValid, redirectPc     branch/jump redirect from execute
//   fetchedCount, starvedCycles   perf counters (FETCH_PERF_COUNTERS_EN only)
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   resetN,
    output logic                   imemReqValid,
    input  logic                   imemReqReady,
    output logic [ADDR_WIDTH-1:0]  imemReqAddr,
    input  logic                   imemRespValid,
    input  logic [INSTR_WIDTH-1:0] imemRespData,
    output logic                   instrValid,
    input  logic                   instrReady,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  instrPc,
    input  logic                   redirectValid,
    input  logic [ADDR_WIDTH-1:0]  redirectPc
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]            fetchedCount,
    output logic [31:0]            starvedCycles
`endif
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int REC_W = INSTR_WIDTH + ADDR_WIDTH;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] reqPc_q, reqPc_d;
    logic                  reqValid;
    logic                  queuePush;
    logic                  queuePop;
    logic [REC_W-1:0]      headData;
    logic [CNT_W-1:0]      queueCount;
    logic                  unusedRedirectBits;

    // Low address bits of a redirect target are forced to zero, never used.
    assign unusedRedirectBits = ^redirectPc[1:0];

    // Next-state logic. A request is only issued with no request outstanding
    // and queue space free, so a push can never overflow the queue.
    // Redirect overrides the PC and turns an outstanding response stale.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        reqPc_d   = reqPc_q;
        reqValid  = 1'b0;
        queuePush = 1'b0;
        case (state_q)
            FETCH: begin
                reqValid = resetN && (queueCount < CNT_W'(QUEUE_DEPTH)) && !redirectValid;
                if (reqValid && imemReqReady) begin
                    reqPc_d = pc_q;
                    pc_d    = pc_q + ADDR_WIDTH'(PC_STEP);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imemRespValid) begin
                    queuePush = !redirectValid;
                    state_d   = FETCH;
                end else if (redirectValid) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (imemRespValid) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        if (redirectValid) begin
            pc_d = {redirectPc[ADDR_WIDTH-1:2], 2'b00};
        end
    end

    // Reset beats a redirect arriving on the same edge.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            reqPc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            reqPc_q <= reqPc_d;
        end
    end

    assign queuePop = instrValid && instrReady && !redirectValid;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (REC_W),
        .CNT_W (CNT_W)
    ) uQueue (
        .clock    (clock),
        .resetN   (resetN),
        .flush    (redirectValid),
        .push     (queuePush),
        .pushData ({imemRespData, reqPc_q}),
        .pop      (queuePop),
        .headData (headData),
        .count    (queueCount)
    );

    // Outputs toward memory and decode are held quiet while reset is asserted.
    assign imemReqValid = reqValid;
    assign imemReqAddr  = pc_q;
    assign instrValid   = resetN && (queueCount != '0);
    assign instruction  = resetN ? headData[REC_W-1:ADDR_WIDTH] : '0;
    assign instrPc      = resetN ? headData[ADDR_WIDTH-1:0] : '0;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetchedCount_q;
    logic [31:0] starvedCycles_q;

    // Free-running counters; redirects deliberately do not clear them.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            fetchedCount_q  <= '0;
            starvedCycles_q <= '0;
        end else begin
            if (queuePush) begin
                fetchedCount_q <= fetchedCount_q + 32'd1;
            end
            if (!instrValid) begin
                starvedCycles_q <= starvedCycles_q + 32'd1;
            end
        end
    end

    assign fetchedCount  = fetchedCount_q;
    assign starvedCycles = starvedCycles_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Cycle-by-cycle directed vectors for instruction_fetch_unit with the default
// parameters (ADDR_WIDTH=32, RESET_PC=0, QUEUE_DEPTH=2), followed by a short
// hand-written sequence for PC wraparound.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        resetN;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemReqAddr;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instruction;
    logic [31:0] instrPc;
    logic        redirectValid;
    logic [31:0] redirectPc;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetchedCount;
    logic [31:0] starvedCycles;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    instruction_fetch_unit #(
        .ADDR_WIDTH  (32),
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .imemReqValid  (imemReqValid),
        .imemReqReady  (imemReqReady),
        .imemReqAddr   (imemReqAddr),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .instrValid    (instrValid),
        .instrReady    (instrReady),
        .instruction   (instruction),
        .instrPc       (instrPc),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .fetchedCount  (fetchedCount),
        .starvedCycles (starvedCycles)
`endif
    );

    typedef struct {
        logic        resetN;
        logic        reqReady;
        logic        respValid;
        logic [31:0] respData;
        logic        instrReady;
        logic        redirValid;
        logic [31:0] redirPc;
        logic        expReqValid;
        logic        chkAddr;
        logic [31:0] expAddr;
        logic        expInstrValid;
        logic        chkHead;
        logic [31:0] expInstr;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] D0   = 32'hA000_0000;
    localparam logic [31:0] D4   = 32'hA000_0004;
    localparam logic [31:0] D8   = 32'hA000_0008;
    localparam logic [31:0] DC   = 32'hA000_000C;
    localparam logic [31:0] E100 = 32'hE000_0100;
    localparam logic [31:0] E200 = 32'hE000_0200;
    localparam logic [31:0] F000 = 32'hF000_0000;

    function automatic void addVec(
        input logic rN, input logic rdy, input logic rv, input logic [31:0] rd,
        input logic ir, input logic rdir, input logic [31:0] rpc,
        input logic eRqv, input logic chkA, input logic [31:0] eAddr,
        input logic eIv, input logic chkH, input logic [31:0] eInstr,
        input logic [31:0] ePc);
        vec_t v;
        v.resetN = rN; v.reqReady = rdy; v.respValid = rv; v.respData = rd;
        v.instrReady = ir; v.redirValid = rdir; v.redirPc = rpc;
        v.expReqValid = eRqv; v.chkAddr = chkA; v.expAddr = eAddr;
        v.expInstrValid = eIv; v.chkHead = chkH; v.expInstr = eInstr;
        v.expPc = ePc;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        resetN        = v.resetN;
        imemReqReady  = v.reqReady;
        imemRespValid = v.respValid;
        imemRespData  = v.respData;
        instrReady    = v.instrReady;
        redirectValid = v.redirValid;
        redirectPc    = v.redirPc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkVec(input int idx, input vec_t v);
        checkOutput($sformatf("vec%0d imemReqValid", idx), {31'd0, imemReqValid}, {31'd0, v.expReqValid});
        if (v.chkAddr) begin
            checkOutput($sformatf("vec%0d imemReqAddr", idx), imemReqAddr, v.expAddr);
        end
        checkOutput($sformatf("vec%0d instrValid", idx), {31'd0, instrValid}, {31'd0, v.expInstrValid});
        if (v.chkHead) begin
            checkOutput($sformatf("vec%0d instruction", idx), instruction, v.expInstr);
            checkOutput($sformatf("vec%0d instrPc", idx), instrPc, v.expPc);
        end
    endtask

    initial begin
        vec_t h;

        // Reset, then streaming fetch with a one-cycle memory.
        addVec(0,0,0,0,    0,0,0,        0,0,32'h0,   0,1,0,0);
        addVec(0,0,0,0,    0,0,0,        0,1,32'h0,   0,1,0,0);
        addVec(1,1,0,0,    1,0,0,        1,1,32'h0,   0,0,0,0);
        addVec(1,1,1,D0,   1,0,0,        0,1,32'h4,   0,0,0,0);
        addVec(1,1,0,0,    1,0,0,        1,1,32'h4,   1,1,D0,32'h0);
        addVec(1,1,1,D4,   1,0,0,        0,1,32'h8,   0,0,0,0);
        addVec(1,1,0,0,    1,0,0,        1,1,32'h8,   1,1,D4,32'h4);
        addVec(1,1,1,D8,   1,0,0,        0,1,32'hC,   0,0,0,0);
        // Decode stalls: queue fills to two entries, requests stop.
        addVec(1,1,0,0,    0,0,0,        1,1,32'hC,   1,1,D8,32'h8);
        addVec(1,1,1,DC,   0,0,0,        0,1,32'h10,  1,1,D8,32'h8);
        addVec(1,1,0,0,    0,0,0,        0,1,32'h10,  1,1,D8,32'h8);
        addVec(1,1,0,0,    0,0,0,        0,1,32'h10,  1,1,D8,32'h8);
        addVec(1,1,0,0,    1,0,0,        0,1,32'h10,  1,1,D8,32'h8);
        addVec(1,1,0,0,    0,0,0,        1,1,32'h10,  1,1,DC,32'hC);
        // Redirect while waiting; late response is dropped.
        addVec(1,1,0,0,    0,1,32'h103,  0,1,32'h14,  1,1,DC,32'hC);
        addVec(1,1,0,0,    0,0,0,        0,1,32'h100, 0,0,0,0);
        addVec(1,1,0,0,    0,0,0,        0,1,32'h100, 0,0,0,0);
        addVec(1,1,1,32'hDEAD_BEEF, 0,0,0, 0,1,32'h100, 0,0,0,0);
        addVec(1,1,0,0,    1,0,0,        1,1,32'h100, 0,0,0,0);
        addVec(1,1,1,E100, 1,0,0,        0,1,32'h104, 0,0,0,0);
        addVec(1,1,0,0,    0,0,0,        1,1,32'h104, 1,1,E100,32'h100);
        // Redirect coinciding with the response.
        addVec(1,1,1,32'hBAD0_0000, 0,1,32'h200, 0,1,32'h108, 1,1,E100,32'h100);
        addVec(1,1,0,0,    1,0,0,        1,1,32'h200, 0,0,0,0);
        addVec(1,1,1,E200, 1,0,0,        0,1,32'h204, 0,0,0,0);
        // Memory not ready for five cycles: request held stable.
        for (int i = 0; i < 5; i++) begin
            addVec(1,0,0,0, 0,0,0,       1,1,32'h204, 1,1,E200,32'h200);
        end
        addVec(1,1,0,0,    0,0,0,        1,1,32'h204, 1,1,E200,32'h200);
        // Reset while waiting, stale response after release.
        addVec(0,0,0,0,    0,0,0,        0,1,32'h208, 0,1,0,0);
        addVec(1,0,1,32'h5A5A_5A5A, 0,0,0, 1,1,32'h0, 0,0,0,0);
        addVec(1,1,0,0,    1,0,0,        1,1,32'h0,   0,0,0,0);
        addVec(1,1,1,F000, 1,0,0,        0,1,32'h4,   0,0,0,0);
        // Redirect in FETCH suppresses the request and flushes without a pop.
        addVec(1,1,0,0,    1,1,32'h300,  0,1,32'h4,   1,1,F000,32'h0);
        addVec(1,0,0,0,    1,0,0,        1,1,32'h300, 0,0,0,0);

        applyStimulus(vecs[0]);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #3;
            checkVec(i, vecs[i]);
            @(posedge clock);
            #1;
        end

        // PC wraparound: redirect to the last word, fetch, then next PC is 0.
        h = vecs[vecs.size() - 1];
        h.reqReady = 1'b0; h.redirValid = 1'b1; h.redirPc = 32'hFFFF_FFFF;
        h.respValid = 1'b0; h.instrReady = 1'b0;
        applyStimulus(h);
        @(posedge clock);
        #1;
        h.redirValid = 1'b0; h.reqReady = 1'b1;
        applyStimulus(h);
        #3;
        checkOutput("wrap reqValid", {31'd0, imemReqValid}, 32'd1);
        checkOutput("wrap reqAddr", imemReqAddr, 32'hFFFF_FFFC);
        @(posedge clock);
        #1;
        h.respValid = 1'b1; h.respData = 32'hCAFE_0001;
        applyStimulus(h);
        #3;
        checkOutput("wrap nextAddr", imemReqAddr, 32'h0);
        @(posedge clock);
        #1;
        h.respValid = 1'b0; h.reqReady = 1'b0; h.instrReady = 1'b1;
        applyStimulus(h);
        #3;
        checkOutput("wrap instrValid", {31'd0, instrValid}, 32'd1);
        checkOutput("wrap instruction", instruction, 32'hCAFE_0001);
        checkOutput("wrap instrPc", instrPc, 32'hFFFF_FFFC);
        @(posedge clock);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
